logic_op_arbiter: RTL and testbench
===================================

# logic_op_arbiter

Shares one WIDTH-bit bitwise logic unit, built from the team's Nand-derived gate library (And, Or, Not, Nor, Xor, Nand), among four requesters. Each requester submits an opcode and two operands over a valid/ready handshake. A round-robin arbiter grants one request at a time, the shared unit evaluates it, and the registered result returns on a single response channel tagged with the requester ID. The block sits between the gate-level datapath and any client logic that needs on-demand bitwise operations without duplicating gate arrays.

## Interface
- WIDTH, 8, operand and result width in bits (WIDTH ≥ 1)
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  4  per-requester request valid; bit i belongs to requester i
- req_ready  out  4  one-hot grant/accept strobe; zero or one bit set
- req_op  in  12  3-bit opcode per requester; requester i uses bits [3i+2:3i]
- req_a  in  4*WIDTH  operand A per requester; requester i uses slice [WIDTH*i +: WIDTH]
- req_b  in  4*WIDTH  operand B per requester; same slicing as req_a
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  2  index of the requester that owns the response
- rsp_data  out  WIDTH  result
- rsp_err  out  1  set when the opcode was illegal
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes (all bitwise over WIDTH):
  - 000 = a AND b
  - 001 = a OR b
  - 010 = NOT a (b is ignored)
  - 011 = a NOR b
  - 100 = a XOR b
  - 101 = a NAND b
  - 110 and 111 are illegal: rsp_data = 0, rsp_err = 1.
- The datapath is composed from the gate-library modules; no behavioural operators are used for the logic functions.
- The FSM has three states: IDLE, EXEC, RESP.
  - IDLE: if any req_valid bit is set, grant g is the first set bit searching upward (wrapping) from last_grant+1. req_ready[g] is asserted combinationally in the same cycle. On that edge, op/a/b of requester g are captured, rsp_id is set to g, last_grant is set to g, and the FSM moves to EXEC. If no req_valid bit is set, the FSM stays in IDLE.
  - EXEC: the captured operands pass through the shared unit. The result and error flag are registered into rsp_data/rsp_err, and the FSM moves to RESP.
  - RESP: rsp_valid = 1. rsp_id, rsp_data and rsp_err are held stable until rsp_valid && rsp_ready, then the FSM returns to IDLE.
- req_ready is 0 outside IDLE. No new request is accepted while a response is pending.
- Requesters hold req_valid and their payload stable until their req_ready bit is seen. The arbiter re-evaluates every IDLE cycle, so a request withdrawn before its grant is never captured.
- The round-robin pointer advances only on acceptance, never on response.

## Timing
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0, busy = 0
  - state = IDLE
  - last_grant = 3, so requester 0 has first priority after reset
- Latency: request accepted on edge T → rsp_valid high in the cycle after edge T+1 (2 cycles).
- Minimum issue interval: 3 cycles per transaction when rsp_ready is tied high.
- Back-pressure: rsp_ready low holds the FSM in RESP indefinitely, with outputs stable.
- Simultaneous requests: exactly one is granted per IDLE cycle; the others wait. With all four held valid continuously, the grant order is 0,1,2,3,0,…
- A new request arriving in the same cycle the FSM returns to IDLE is eligible at the next IDLE cycle; the FSM never goes from RESP directly to EXEC.
- Reset asserted mid-transaction: all outputs drop to reset values asynchronously, the in-flight transaction is discarded with no response, and the pointer returns to 3.

## Test plan
- WIDTH=8, reset, then requester 2 only, op=100, a=0xF0, b=0x3C → req_ready=0b0100 for one cycle; two cycles later rsp_valid=1, rsp_id=2, rsp_data=0xCC, rsp_err=0.
- All four opcodes 000/001/011/101 from requester 0 with a=0xA5, b=0x0F → rsp_data 0x05, 0xAF, 0x50, 0xFA respectively. Op 010 with a=0xA5 → 0x5A.
- All four req_valid held high for 8 transactions with rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1,2,3, each spaced 3 cycles.
- Illegal op=111 from requester 3 → rsp_err=1, rsp_data=0x00, rsp_id=3; the next legal request completes with rsp_err=0.
- rsp_ready held low for 10 cycles in RESP → rsp_valid, rsp_id and rsp_data stable; req_ready=0 throughout; busy=1.
- rst_n pulsed low during EXEC → all outputs 0 immediately. After release, requesters 1 and 3 valid → requester 1 is granted first.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// Nand: the primitive cell of the gate library; every other gate is built from it.
// Latency: combinational.
// Backpressure: none.
module Nand #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = ~(a & b);
endmodule

// Not: a Nand with both inputs tied together.
// Latency: combinational.
// Backpressure: none.
module Not #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    Nand #(.WIDTH(WIDTH)) u_nand (.a(a), .b(a), .y(y));
endmodule

// And: a Nand followed by Not.
// Latency: combinational.
// Backpressure: none.
module And #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] n;
    Nand #(.WIDTH(WIDTH)) u_nand (.a(a), .b(b), .y(n));
    Not  #(.WIDTH(WIDTH)) u_not  (.a(n), .y(y));
endmodule

// Or: De Morgan form, Nand of the inverted inputs.
// Latency: combinational.
// Backpressure: none.
module Or #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] na;
    logic [WIDTH-1:0] nb;
    Not  #(.WIDTH(WIDTH)) u_not_a (.a(a), .y(na));
    Not  #(.WIDTH(WIDTH)) u_not_b (.a(b), .y(nb));
    Nand #(.WIDTH(WIDTH)) u_nand  (.a(na), .b(nb), .y(y));
endmodule

// Nor: an Or followed by Not.
// Latency: combinational.
// Backpressure: none.
module Nor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] o;
    Or  #(.WIDTH(WIDTH)) u_or  (.a(a), .b(b), .y(o));
    Not #(.WIDTH(WIDTH)) u_not (.a(o), .y(y));
endmodule

// Xor: the classic four-Nand structure.
// Latency: combinational.
// Backpressure: none.
module Xor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH-1:0] n_ab;
    logic [WIDTH-1:0] n_a;
    logic [WIDTH-1:0] n_b;
    Nand #(.WIDTH(WIDTH)) u_n0 (.a(a),   .b(b),    .y(n_ab));
    Nand #(.WIDTH(WIDTH)) u_n1 (.a(a),   .b(n_ab), .y(n_a));
    Nand #(.WIDTH(WIDTH)) u_n2 (.a(b),   .b(n_ab), .y(n_b));
    Nand #(.WIDTH(WIDTH)) u_n3 (.a(n_a), .b(n_b),  .y(y));
endmodule

// logic_op_arbiter: four requesters share one gate-built bitwise unit, round-robin arbitrated.
// Latency: accept on edge T, rsp_valid from edge T+1; one transaction every 3 cycles at best.
// Backpressure: rsp_ready low parks the FSM in RESP with outputs frozen; req_ready is 0 outside IDLE.
// Ports: req_valid/req_ready/req_op/req_a/req_b per requester (packed, requester i in slice i);
//        rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err shared response channel; busy = not IDLE.
module logic_op_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req_valid,
    output logic [3:0]         req_ready,
    input  logic [11:0]        req_op,
    input  logic [4*WIDTH-1:0] req_a,
    input  logic [4*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    logic [1:0]       last_grant;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic [1:0]       grant_idx;
    logic             grant_any;

    // Round-robin search: first valid requester strictly after last_grant,
    // wrapping modulo 4 (the 2-bit sum wraps on its own).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_any && req_valid[last_grant + 2'(k)]) begin
                grant_any = 1'b1;
                grant_idx = last_grant + 2'(k);
            end
        end
    end

    // Gating with rst_n keeps the strobe low while reset is held, even if
    // a requester is already presenting valid.
    always_comb begin
        req_ready = 4'b0000;
        if (rst_n && state == IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Shared unit: every function is computed from the gate library and the
    // opcode merely selects one of them.
    logic [WIDTH-1:0] and_y;
    logic [WIDTH-1:0] or_y;
    logic [WIDTH-1:0] not_y;
    logic [WIDTH-1:0] nor_y;
    logic [WIDTH-1:0] xor_y;
    logic [WIDTH-1:0] nand_y;

    And  #(.WIDTH(WIDTH)) u_and  (.a(a_q), .b(b_q), .y(and_y));
    Or   #(.WIDTH(WIDTH)) u_or   (.a(a_q), .b(b_q), .y(or_y));
    Not  #(.WIDTH(WIDTH)) u_not  (.a(a_q),          .y(not_y));
    Nor  #(.WIDTH(WIDTH)) u_nor  (.a(a_q), .b(b_q), .y(nor_y));
    Xor  #(.WIDTH(WIDTH)) u_xor  (.a(a_q), .b(b_q), .y(xor_y));
    Nand #(.WIDTH(WIDTH)) u_nand (.a(a_q), .b(b_q), .y(nand_y));

    logic [WIDTH-1:0] unit_res;
    logic             unit_err;

    always_comb begin
        unit_res = '0;
        unit_err = 1'b0;
        case (op_q)
            3'b000:  unit_res = and_y;
            3'b001:  unit_res = or_y;
            3'b010:  unit_res = not_y;
            3'b011:  unit_res = nor_y;
            3'b100:  unit_res = xor_y;
            3'b101:  unit_res = nand_y;
            default: unit_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 2'd3;
            op_q       <= 3'b000;
            a_q        <= '0;
            b_q        <= '0;
            rsp_id     <= 2'd0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_q       <= req_op[3*int'(grant_idx) +: 3];
                        a_q        <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
                        b_q        <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
                        rsp_id     <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data <= unit_res;
                    rsp_err  <= unit_err;
                    state    <= RESP;
                end
                RESP: begin
                    // Always back through IDLE so arbitration sees a full cycle.
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
endmodule

// File: tb/tb_logic_op_arbiter.sv
module tb_logic_op_arbiter;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         req_valid;
    logic [3:0]         req_ready;
    logic [11:0]        req_op;
    logic [4*WIDTH-1:0] req_a;
    logic [4*WIDTH-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [1:0]         rsp_id;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_err;
    logic               busy;

    int tests = 0;
    int fails = 0;

    logic_op_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Drives one request from requester id and returns what came back.
    // Entered and left on a falling edge; got_vld=0 means a bound expired.
    task automatic run_txn(input int id, input logic [2:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           output logic [1:0] got_id, output logic [7:0] got_data,
                           output logic got_err, output logic got_vld);
        bit granted = 0;
        got_vld  = 1'b0;
        got_id   = 2'd0;
        got_data = 8'h00;
        got_err  = 1'b0;
        req_op[3*id +: 3]         = op;
        req_a[WIDTH*id +: WIDTH]  = a;
        req_b[WIDTH*id +: WIDTH]  = b;
        req_valid[id]             = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (req_ready[id]) begin granted = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        if (granted) begin
            for (int c = 0; c < 20; c++) begin
                if (rsp_valid) begin
                    got_vld  = 1'b1;
                    got_id   = rsp_id;
                    got_data = rsp_data;
                    got_err  = rsp_err;
                    break;
                end
                @(negedge clk);
            end
            if (rsp_ready) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 17'd0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b id=%0d data=%h err=%b busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b vld=%b, want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_single_xor();
        req_op[8:6]  = 3'b100;
        req_a[23:16] = 8'hF0;
        req_b[23:16] = 8'h3C;
        req_valid    = 4'b0100;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL single_grant: got req_ready=%b, want 0100", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        tests++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_exec: got rdy=%b vld=%b busy=%b, want 0000 0 1", req_ready, rsp_valid, busy);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hCC || rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL single_rsp: got vld=%b id=%0d data=%h err=%b, want 1 2 cc 0",
                     rsp_valid, rsp_id, rsp_data, rsp_err);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: got vld=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_opcodes();
        logic [2:0] ops  [5] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b010};
        logic [7:0] want [5] = '{8'h05, 8'hAF, 8'h50, 8'hFA, 8'h5A};
        logic [1:0] gid;
        logic [7:0] gdata;
        logic       gerr;
        logic       gvld;
        for (int i = 0; i < 5; i++) begin
            run_txn(0, ops[i], 8'hA5, 8'h0F, gid, gdata, gerr, gvld);
            tests++;
            if (gvld !== 1'b1 || gid !== 2'd0 || gdata !== want[i] || gerr !== 1'b0) begin
                fails++;
                $display("FAIL op_%b: got vld=%b id=%0d data=%h err=%b, want 1 0 %h 0",
                         ops[i], gvld, gid, gdata, gerr, want[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [1:0] gid;
        logic [7:0] gdata;
        logic       gerr;
        logic       gvld;
        run_txn(3, 3'b111, 8'hFF, 8'hFF, gid, gdata, gerr, gvld);
        tests++;
        if (gvld !== 1'b1 || gid !== 2'd3 || gdata !== 8'h00 || gerr !== 1'b1) begin
            fails++;
            $display("FAIL illegal_op: got vld=%b id=%0d data=%h err=%b, want 1 3 00 1", gvld, gid, gdata, gerr);
        end
        run_txn(3, 3'b100, 8'hFF, 8'h0F, gid, gdata, gerr, gvld);
        tests++;
        if (gvld !== 1'b1 || gid !== 2'd3 || gdata !== 8'hF0 || gerr !== 1'b0) begin
            fails++;
            $display("FAIL after_illegal: got vld=%b id=%0d data=%h err=%b, want 1 3 f0 0", gvld, gid, gdata, gerr);
        end
    endtask

    // Pointer is 3 on entry, so the order must start at requester 0.
    task automatic test_round_robin();
        int n = 0;
        int cyc = 0;
        int last_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            req_op[3*i +: 3]        = 3'b000;
            req_a[WIDTH*i +: WIDTH] = 8'hFF;
            req_b[WIDTH*i +: WIDTH] = 8'(8'h11 * (i + 1));
        end
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 100 && n < 8; c++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                tests++;
                if (rsp_id !== 2'(n % 4) || rsp_data !== 8'(8'h11 * (n % 4 + 1))) begin
                    fails++;
                    $display("FAIL rr_order_%0d: got id=%0d data=%h, want %0d %h",
                             n, rsp_id, rsp_data, n % 4, 8'(8'h11 * (n % 4 + 1)));
                end
                if (n > 0) begin
                    tests++;
                    if (cyc - last_cyc != 3) begin
                        fails++;
                        $display("FAIL rr_spacing_%0d: got %0d cycles, want 3", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
                if (n == 8) req_valid = 4'b0000;
            end
        end
        req_valid = 4'b0000;
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL rr_count: got %0d responses, want 8", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit stable_ok = 1;
        rsp_ready    = 1'b0;
        req_op[5:3]  = 3'b001;
        req_a[15:8]  = 8'h30;
        req_b[15:8]  = 8'h03;
        req_valid    = 4'b0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        req_valid = 4'b1111;   // everyone asks while the response is pending
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'h33 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                stable_ok = 0;
                $display("FAIL bp_hold_c%0d: got vld=%b id=%0d data=%h rdy=%b busy=%b, want 1 1 33 0000 1",
                         c, rsp_valid, rsp_id, rsp_data, req_ready, busy);
            end
            @(negedge clk);
        end
        tests++;
        if (!stable_ok) fails++;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got vld=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_midflight();
        logic [1:0] gid;
        logic [7:0] gdata;
        logic       gerr;
        logic       gvld;
        req_op[8:6]  = 3'b000;
        req_a[23:16] = 8'hFF;
        req_b[23:16] = 8'h77;
        req_valid    = 4'b0100;
        @(posedge clk);
        @(negedge clk);       // now in EXEC, rsp_id already 2, rsp_data still 0x33
        req_valid = 4'b0000;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy} !== 17'd0) begin
            fails++;
            $display("FAIL midflight_reset: got rdy=%b vld=%b id=%0d data=%h err=%b busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL midflight_discard: got rsp_valid=%b, want 0", rsp_valid);
        end
        req_op[5:3]   = 3'b001; req_a[15:8]  = 8'h01; req_b[15:8]  = 8'h10;
        req_op[11:9]  = 3'b001; req_a[31:24] = 8'h02; req_b[31:24] = 8'h20;
        req_valid = 4'b1010;
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL midflight_ptr: got req_ready=%b, want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        run_txn(3, 3'b001, 8'h02, 8'h20, gid, gdata, gerr, gvld);
        tests++;
        if (gvld !== 1'b1 || gid !== 2'd3 || gdata !== 8'h22) begin
            fails++;
            $display("FAIL midflight_second: got vld=%b id=%0d data=%h, want 1 3 22", gvld, gid, gdata);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_xor();
        test_opcodes();
        test_illegal();
        test_round_robin();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
